// File: rtl/digit_scan_counter.sv
`default_nettype none
// ============================================================================
// Module   : digit_scan_counter
// Purpose  : Two-digit BCD up/down counter with synchronous load and a
//            multiplexed display scan for a seven-segment decoder. The scan
//            alternates between the units and tens digits every SCAN_DIV
//            clock cycles and presents the selected digit on {w,x,y,z}.
// Ports    : clk        - clock, all state updates on its rising edge
//            rst_n      - synchronous active-low reset
//            en         - count enable, one BCD step per cycle
//            up         - direction, 1 = up, 0 = down
//            load       - synchronous load strobe (priority over en)
//            load_val   - BCD value to load, [7:4] tens, [3:0] units
//            count      - registered BCD count, [7:4] tens, [3:0] units
//            w,x,y,z    - registered nibble of the selected digit (w = MSB)
//            digit_sel  - one-hot digit enable, bit0 units, bit1 tens
//            carry      - one-cycle pulse after a wrap in either direction
// Revision : 1.0 - initial release
// ============================================================================
module digit_scan_counter #(
    parameter int SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] count,
    output logic       w,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic [1:0] digit_sel,
    output logic       carry
);

    // Prescaler is 8 bits wide, enough for the full 2..255 range.
    localparam logic [7:0] c_PRE_LAST = 8'(SCAN_DIV - 1);

    logic [7:0] r_pre;
    logic [3:0] r_nib;

    logic [7:0] w_next_count;
    logic       w_wrap;
    logic       w_pre_last;
    logic [1:0] w_next_sel;
    logic [3:0] w_nib_src;

    // Loaded digits above 9 saturate at 9 so the count is always valid BCD.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Next count and wrap detection. Load wins over en, so a load never
    // produces a carry even when the loaded value is 00 or 99.
    always_comb begin
        w_next_count = count;
        w_wrap       = 1'b0;
        if (load) begin
            w_next_count = {clamp_digit(load_val[7:4]), clamp_digit(load_val[3:0])};
        end else if (en) begin
            if (up) begin
                if (count[3:0] == 4'd9) begin
                    w_next_count[3:0] = 4'd0;
                    if (count[7:4] == 4'd9) begin
                        w_next_count[7:4] = 4'd0;
                        w_wrap            = 1'b1;
                    end else begin
                        w_next_count[7:4] = count[7:4] + 4'd1;
                    end
                end else begin
                    w_next_count[3:0] = count[3:0] + 4'd1;
                end
            end else begin
                if (count[3:0] == 4'd0) begin
                    w_next_count[3:0] = 4'd9;
                    if (count[7:4] == 4'd0) begin
                        w_next_count[7:4] = 4'd9;
                        w_wrap            = 1'b1;
                    end else begin
                        w_next_count[7:4] = count[7:4] - 4'd1;
                    end
                end else begin
                    w_next_count[3:0] = count[3:0] - 4'd1;
                end
            end
        end
    end

    // The nibble is chosen by the digit_sel value that will be live after
    // this edge, so nibble and select always update together and agree.
    assign w_pre_last = (r_pre == c_PRE_LAST);
    assign w_next_sel = w_pre_last ? ~digit_sel : digit_sel;
    assign w_nib_src  = w_next_sel[0] ? count[3:0] : count[7:4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= 8'h00;
            carry     <= 1'b0;
            r_pre     <= 8'd0;
            digit_sel <= 2'b01;
            r_nib     <= 4'b0000;
        end else begin
            count     <= w_next_count;
            carry     <= w_wrap;
            r_pre     <= w_pre_last ? 8'd0 : r_pre + 8'd1;
            digit_sel <= w_next_sel;
            r_nib     <= w_nib_src;
        end
    end

    assign {w, x, y, z} = r_nib;

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_scan_counter
// Purpose  : Self-checking bench for digit_scan_counter (SCAN_DIV = 4).
//            Directed vectors with hand-computed expectations plus a
//            randomised run compared against an integer reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_scan_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       w, x, y, z;
    logic [1:0] digit_sel;
    logic       carry;
    logic [3:0] nib;

    int checks = 0;
    int errors = 0;

    digit_scan_counter #(.SCAN_DIV(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .up        (up),
        .load      (load),
        .load_val  (load_val),
        .count     (count),
        .w         (w),
        .x         (x),
        .y         (y),
        .z         (z),
        .digit_sel (digit_sel),
        .carry     (carry)
    );

    assign nib = {w, x, y, z};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    initial begin
        int         pulses;
        int         mv;
        logic       mc;
        logic [7:0] pc;
        logic [3:0] exp_nib;
        int         t;
        int         u;

        rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
        #2;

        // Reset state
        step();
        check_val("rst_count", 32'(count), 32'h00);
        check_val("rst_sel",   32'(digit_sel), 32'h1);
        check_val("rst_nib",   32'(nib), 32'h0);
        check_val("rst_carry", 32'(carry), 32'h0);

        // Up-count 100 steps: 00..99 and back to 00 with one carry pulse
        rst_n = 1'b1; en = 1'b1; up = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (carry) pulses++;
            check_val("up_count", 32'(count), 32'(to_bcd(i % 100)));
            check_val("up_carry", 32'(carry), 32'(i == 100));
        end
        check_val("up_carry_pulses", 32'(pulses), 32'd1);

        // Load 00, one down step wraps to 99 with carry, next gives 98
        en = 1'b0; load = 1'b1; load_val = 8'h00;
        step();
        check_val("ld00_count", 32'(count), 32'h00);
        check_val("ld00_carry", 32'(carry), 32'h0);
        load = 1'b0; en = 1'b1; up = 1'b0;
        step();
        check_val("dn_wrap_count", 32'(count), 32'h99);
        check_val("dn_wrap_carry", 32'(carry), 32'h1);
        step();
        check_val("dn_98_count", 32'(count), 32'h98);
        check_val("dn_98_carry", 32'(carry), 32'h0);

        // Down 20 -> 19 across tens borrow
        en = 1'b0; load = 1'b1; load_val = 8'h20;
        step();
        load = 1'b0; en = 1'b1; up = 1'b0;
        step();
        check_val("dn_20_19", 32'(count), 32'h19);

        // Load with en in the same cycle, units clamped
        load = 1'b1; en = 1'b1; up = 1'b1; load_val = 8'h5C;
        step();
        check_val("ld5C_count", 32'(count), 32'h59);
        check_val("ld5C_carry", 32'(carry), 32'h0);

        // Clamping of each digit independently
        load_val = 8'hA3;
        step();
        check_val("ldA3_count", 32'(count), 32'h93);
        load_val = 8'hFF;
        step();
        check_val("ldFF_count", 32'(count), 32'h99);

        // Load 99 while at 99 with en/up: no carry on load cycles
        load_val = 8'h99;
        step();
        check_val("ld99_count", 32'(count), 32'h99);
        check_val("ld99_carry", 32'(carry), 32'h0);

        // Hold with en=0
        load = 1'b0; en = 1'b0;
        step();
        step();
        check_val("hold_count", 32'(count), 32'h99);
        check_val("hold_carry", 32'(carry), 32'h0);

        // Reset at 99 with en=1 up=1 (a wrap cycle): reset wins, no carry
        en = 1'b1; up = 1'b1; rst_n = 1'b0;
        step();
        check_val("rstwrap_count", 32'(count), 32'h00);
        check_val("rstwrap_carry", 32'(carry), 32'h0);
        check_val("rstwrap_sel",   32'(digit_sel), 32'h1);
        check_val("rstwrap_nib",   32'(nib), 32'h0);
        rst_n = 1'b1; en = 1'b0;
        step();
        check_val("rstwrap_nocarry", 32'(carry), 32'h0);
        check_val("rstwrap_hold",    32'(count), 32'h00);

        // Scan pattern with count held at 37, starting from reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; load = 1'b1; load_val = 8'h37;
        step();
        // Edge 1 after reset: nibble sampled count 00 before the load landed
        check_val("scan_k1_sel", 32'(digit_sel), 32'h1);
        check_val("scan_k1_nib", 32'(nib), 32'h0);
        load = 1'b0;
        for (int k = 2; k <= 16; k++) begin
            step();
            if (((k / 4) % 2) == 0) begin
                check_val("scan_sel", 32'(digit_sel), 32'h1);
                check_val("scan_nib", 32'(nib), 32'h7);
            end else begin
                check_val("scan_sel", 32'(digit_sel), 32'h2);
                check_val("scan_nib", 32'(nib), 32'h3);
            end
        end
        check_val("scan_count", 32'(count), 32'h37);

        // Random run against an integer reference model
        rst_n = 1'b0; load = 1'b0; en = 1'b0;
        step();
        rst_n = 1'b1;
        mv = 0;
        mc = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            en       = 1'($urandom);
            up       = 1'($urandom);
            load     = ($urandom_range(0, 7) == 0);
            load_val = 8'($urandom);
            if (load) begin
                t = int'(load_val[7:4]);
                u = int'(load_val[3:0]);
                if (t > 9) t = 9;
                if (u > 9) u = 9;
                mv = t * 10 + u;
                mc = 1'b0;
            end else if (en) begin
                if (up) begin
                    mc = (mv == 99);
                    mv = (mv + 1) % 100;
                end else begin
                    mc = (mv == 0);
                    mv = (mv + 99) % 100;
                end
            end else begin
                mc = 1'b0;
            end
            pc = count;
            step();
            exp_nib = digit_sel[0] ? pc[3:0] : pc[7:4];
            check_val("rnd_count",  32'(count), 32'(to_bcd(mv)));
            check_val("rnd_carry",  32'(carry), 32'(mc));
            check_val("rnd_onehot", 32'($onehot(digit_sel)), 32'h1);
            check_val("rnd_nib_le9", 32'(nib <= 4'd9), 32'h1);
            check_val("rnd_nib",    32'(nib), 32'(exp_nib));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
